// File: rtl/trace_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the commit trace unit:
//   XLEN_DEF       default pc / instruction width
//   HALT_INST_DEF  default encoding of the program-end instruction
//   NOP_INST       canonical RISC-V nop (addi x0, x0, 0)
//   trace_rec_t    one trace record {pc, inst, seq}
//   ptr_width()    pointer width for a circular buffer with a wrap bit
// ---------------------------------------------------------------------------
package trace_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] HALT_INST_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST      = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] inst;
    logic [31:0]         seq;
  } trace_rec_t;

  // Index bits plus one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/commit_trace_unit_if.sv
// ---------------------------------------------------------------------------
// commit_trace_unit_if
// Valid/ready trace record bus between the trace unit and its consumer.
//   trace_valid_o  record available (driven by master)
//   trace_ready_i  consumer accepts record (driven by slave)
//   trace_pc_o     retired pc
//   trace_inst_o   retired instruction
//   trace_seq_o    retire sequence number
// ---------------------------------------------------------------------------
interface commit_trace_unit_if #(
  parameter int XLEN = 32
);

  logic            trace_valid_o;
  logic            trace_ready_i;
  logic [XLEN-1:0] trace_pc_o;
  logic [XLEN-1:0] trace_inst_o;
  logic [31:0]     trace_seq_o;

  modport master (
    output trace_valid_o,
    output trace_pc_o,
    output trace_inst_o,
    output trace_seq_o,
    input  trace_ready_i
  );

  modport slave (
    input  trace_valid_o,
    input  trace_pc_o,
    input  trace_inst_o,
    input  trace_seq_o,
    output trace_ready_i
  );

endinterface

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Synchronous circular-buffer FIFO with a wrap-bit pointer scheme.
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i         write data_i (accepted when not full, or when popping)
//   pop_i          consumer ready; pops the head when not empty
//   data_i         write data
//   full_o         all entries occupied
//   empty_o        no entries
//   data_o         head entry, zero while empty
// A push and a pop in the same cycle are both honoured even when full,
// so a full FIFO being drained at the same rate never loses a record.
// ---------------------------------------------------------------------------
module trace_fifo
  import trace_pkg::*;
#(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  // Same index with opposite wrap bit means the writer lapped the reader.
  assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_pop   = pop_i & ~w_empty;
  assign w_push  = push_i & (~w_full | w_pop);

  // Pointer update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end
  end

  // Head read, forced to zero while empty so an idle bus shows no stale data.
  always_comb begin
    data_o = '0;
    if (w_empty) begin
      data_o = '0;
    end else begin
      data_o = r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  assign full_o  = w_full;
  assign empty_o = w_empty;

endmodule

// File: rtl/commit_trace_unit.sv
// ---------------------------------------------------------------------------
// commit_trace_unit
// Retire tracer for the pipelined RISC-V CPU. {pc, inst} captured in decode
// ride a shadow pipeline that mirrors the CPU's stall/flush behaviour; each
// valid instruction leaving the last shadow stage is pushed into a trace FIFO.
//   clk_i, rst_i       clock, synchronous active-high reset
//   advance_i          CPU pipeline moves this cycle
//   pc_i, inst_i       instruction in decode
//   bubble_i           decode entry is a bubble
//   flush_i            squash the youngest shadow stage
//   trace_if           valid/ready record bus (master side)
//   stall_req_o        FIFO cannot take a retire this cycle
//   halt_o             sticky: HALT_INST retired
//   overflow_o         sticky: a retire was dropped on a full FIFO
//   retired_count_o    total retires (including dropped ones)
// ---------------------------------------------------------------------------
module commit_trace_unit
  import trace_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter int              DEPTH      = 2,
  parameter int              FIFO_DEPTH = 8,
  parameter logic [XLEN-1:0] HALT_INST  = XLEN'(HALT_INST_DEF)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       advance_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [XLEN-1:0]            inst_i,
  input  logic                       bubble_i,
  input  logic                       flush_i,
  commit_trace_unit_if.master        trace_if,
  output logic                       stall_req_o,
  output logic                       halt_o,
  output logic                       overflow_o,
  output logic [31:0]                retired_count_o
);

  localparam int REC_W = 2 * XLEN + 32;

  // Shadow pipeline, index 0 is the youngest (decode capture) stage.
  logic            r_v    [DEPTH];
  logic [XLEN-1:0] r_pc   [DEPTH];
  logic [XLEN-1:0] r_inst [DEPTH];

  logic        r_halt;
  logic        r_overflow;
  logic [31:0] r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_stall;
  logic             w_retire;
  logic             w_push;
  logic             w_is_halt;
  logic [REC_W-1:0] w_push_rec;
  logic [REC_W-1:0] w_head_rec;

  assign w_pop      = ~w_empty & trace_if.trace_ready_i;
  assign w_stall    = w_full & ~w_pop;
  assign w_retire   = advance_i & r_v[DEPTH-1] & ~r_halt;
  assign w_push     = w_retire & ~w_stall;
  assign w_is_halt  = (r_inst[DEPTH-1] == HALT_INST);
  assign w_push_rec = {r_pc[DEPTH-1], r_inst[DEPTH-1], r_count};

  // Shadow pipeline: shift on advance; a flush during a hold still kills stage 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_v[k]    <= 1'b0;
        r_pc[k]   <= '0;
        r_inst[k] <= '0;
      end
    end else if (advance_i) begin
      r_v[0]    <= ~bubble_i & ~flush_i;
      r_pc[0]   <= pc_i;
      r_inst[0] <= inst_i;
      for (int k = 1; k < DEPTH; k++) begin
        r_v[k]    <= r_v[k-1];
        r_pc[k]   <= r_pc[k-1];
        r_inst[k] <= r_inst[k-1];
      end
    end else if (flush_i) begin
      r_v[0] <= 1'b0;
    end
  end

  // Retire bookkeeping: the counter advances even on a dropped record so
  // gaps in the sequence numbers expose the loss.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count    <= 32'd0;
      r_halt     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_retire) begin
        r_count <= r_count + 32'd1;
      end
      if (w_retire && w_is_halt) begin
        r_halt <= 1'b1;
      end
      if (w_retire && w_stall) begin
        r_overflow <= 1'b1;
      end
    end
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (trace_if.trace_ready_i),
    .data_i  (w_push_rec),
    .full_o  (w_full),
    .empty_o (w_empty),
    .data_o  (w_head_rec)
  );

  assign trace_if.trace_valid_o = ~w_empty;
  assign trace_if.trace_pc_o    = w_head_rec[REC_W-1 -: XLEN];
  assign trace_if.trace_inst_o  = w_head_rec[REC_W-1-XLEN -: XLEN];
  assign trace_if.trace_seq_o   = w_head_rec[31:0];

  assign stall_req_o     = w_stall;
  assign halt_o          = r_halt;
  assign overflow_o      = r_overflow;
  assign retired_count_o = r_count;

endmodule
